rsnn_neuron_array: RTL and testbench
====================================

// Module: rsnn_neuron_array
// PURPOSE
//   Parametrised array of N leaky integrate-and-fire neurons with recurrent self and lateral feedback.
//   One shared, time-multiplexed datapath updates one neuron per cycle.
//   A host or sequencer pulses step once per network timestep.
//   Spikes from timestep t feed back into the input current of every neuron at timestep t+1.
// PARAMETERS
//   N_NEURONS  4  number of neurons (>=2)
//   W          8  signed two's-complement width of currents, membrane potential and weights
//   REF_W      8  width of each neuron's refractory counter
// PORTS
//   clk                input   1        clock, all state on rising edge
//   reset              input   1        synchronous reset, active-high
//   enable             input   1        step is accepted only while enable=1
//   step               input   1        start-timestep pulse
//   ext_current        input   N*W      signed external current per neuron; neuron i uses [i*W +: W]
//   threshold          input   W        signed firing threshold, must be >0; compared as v >= threshold
//   decay              input   W        unsigned leak magnitude per timestep
//   refractory_period  input   REF_W    refractory timesteps after a spike
//   self_scale         input   W        signed weight added when the neuron itself spiked last timestep
//   lateral_scale      input   W        signed weight per other neuron that spiked last timestep
//   spike_out          output  N        spike vector of the last completed timestep
//   step_done          output  1        1-cycle pulse when spike_out has been updated
//   busy               output  1        high while a timestep sweep is in progress
// BEHAVIOUR
//   - Reset, synchronous:
//     - spike_out=0, step_done=0, busy=0, FSM=IDLE.
//     - All membrane potentials v[i]=0, refractory counters r[i]=0, prev_spk=0.
//     - Reset in any state aborts the sweep; no partial spike vector is published.
//   - FSM states:
//     - IDLE: step & enable -> UPD with idx=0; busy=1 from the next cycle.
//     - UPD: update neuron idx; idx==N-1 -> DONE, else idx++.
//     - DONE: spike_out<=new_spk, prev_spk<=new_spk, step_done=1 for this cycle, busy=0 -> IDLE.
//   - Latency: step accepted at cycle c gives step_done and the new spike_out at cycle c+N+1.
//     - step while busy or in DONE, or with enable=0, is ignored; no queueing.
//   - Inputs are sampled at the cycle each neuron is updated; the host holds them stable while busy.
//   - Per-neuron update, neuron i, all operands sign-extended to W+clog2(N)+2 bits:
//     - lat = popcount(prev_spk with bit i masked) * lateral_scale
//     - I = sat_W(ext_current[i] + (prev_spk[i] ? self_scale : 0) + lat)
//   - If r[i]>0 (refractory):
//     - r[i]<=r[i]-1, v[i]<=0, new_spk[i]=0. I is discarded.
//   - Else:
//     - Leak toward zero, never crossing it:
//       - v>0: vl = max(v - decay, 0)
//       - v<0: vl = min(v + decay, 0)
//       - v==0: vl = 0
//     - vn = sat_W(vl + I).
//     - vn >= threshold: new_spk[i]=1, v[i]<=0, r[i]<=refractory_period.
//     - Otherwise: new_spk[i]=0, v[i]<=vn.
//   - sat_W clamps to [-2^(W-1), 2^(W-1)-1].
//   - refractory_period=0 means the neuron may fire on consecutive timesteps.
//   - spike_out holds its value between step_done pulses. new_spk is internal and never visible early.
// TESTING
//   - Charge: N=4, W=8; ext=20 on neuron 0, others 0; thr=50; decay=0; refr=0; scales=0.
//     -> spike_out[0]=1 on step 3, 6, 9; other bits stay 0.
//   - Refractory: as above with refr=2.
//     -> spikes on steps 3 and 8; v stays 0 during steps 4-5.
//   - Leak and saturation:
//     - ext=-128, decay=5, thr=100 -> v saturates at -128; never spikes.
//     - Then ext=0 -> v rises 5 per step and stops at 0.
//   - Recurrence:
//     - thr=50, ext0=60, self_scale=60, lateral_scale=-128, ext1..3=40, 3 steps.
//     - Neuron 0 spikes every step. Neurons 1-3 never spike: after step 1 they receive sat(40-128)=-88.
//   - Handshake:
//     - step at cycle c -> busy=1 on cycles c+1..c+N, step_done pulse at c+N+1.
//     - A second step at c+2 or with enable=0 is ignored.
//   - Reset: assert reset at idx=2 mid-sweep.
//     -> next cycle busy=0, spike_out=0, no step_done; the next step behaves as from a fresh start.

Source files
------------

// File: rtl/rsnn_neuron_array.sv
// Array of leaky integrate-and-fire neurons with self and lateral spike feedback.
// A single shared datapath updates one neuron per cycle during each timestep sweep.
module rsnn_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8,
  parameter int REF_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     step,
  input  logic [N_NEURONS*W-1:0]   ext_current,
  input  logic signed [W-1:0]      threshold,
  input  logic [W-1:0]             decay,
  input  logic [REF_W-1:0]         refractory_period,
  input  logic signed [W-1:0]      self_scale,
  input  logic signed [W-1:0]      lateral_scale,
  output logic [N_NEURONS-1:0]     spike_out,
  output logic                     step_done,
  output logic                     busy
);

  // Handshake: step is taken only in IDLE with enable=1; busy is high for the
  // N update cycles, then step_done pulses for one cycle with spike_out updated.
  localparam int IW = $clog2(N_NEURONS);
  localparam int CW = IW + 1;
  localparam int XW = W + IW + 2;

  typedef logic signed [XW-1:0] xw_t;
  typedef enum logic [1:0] {IDLE, UPD, DONE} state_t;

  localparam xw_t SAT_MAX = xw_t'((1 <<< (W - 1)) - 1);
  localparam xw_t SAT_MIN = xw_t'(-(1 <<< (W - 1)));
  localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

  state_t state, state_nxt;
  logic [IW-1:0]          idx;
  logic signed [W-1:0]    v [N_NEURONS];
  logic [REF_W-1:0]       r [N_NEURONS];
  logic [N_NEURONS-1:0]   prev_spk;
  logic [N_NEURONS-1:0]   new_spk;
  logic [N_NEURONS-1:0]   new_spk_full;

  logic [CW-1:0]          cnt;
  logic signed [W-1:0]    ext_i;
  xw_t                    self_x, lat_x, v_x, dec_x, tmp_x, vl_x;
  logic signed [W-1:0]    i_cur, vn, v_nxt;
  logic [REF_W-1:0]       r_nxt;
  logic                   spk_i;

  function automatic logic signed [W-1:0] sat_w(input xw_t x);
    xw_t y;
    if (x > SAT_MAX)      y = SAT_MAX;
    else if (x < SAT_MIN) y = SAT_MIN;
    else                  y = x;
    return y[W-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step && enable) state_nxt = UPD;
      UPD:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == UPD);
  assign step_done = (state == DONE);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (i != int'(idx)) cnt = cnt + CW'(prev_spk[i]);
    end
    ext_i  = $signed(ext_current[int'(idx)*W +: W]);
    self_x = prev_spk[idx] ? xw_t'(self_scale) : '0;
    lat_x  = xw_t'(cnt) * xw_t'(lateral_scale);
    i_cur  = sat_w(xw_t'(ext_i) + self_x + lat_x);

    // Leak pulls v toward zero but never past it.
    v_x   = xw_t'(v[idx]);
    dec_x = xw_t'(decay);
    tmp_x = '0;
    vl_x  = '0;
    if (v_x > 0) begin
      tmp_x = v_x - dec_x;
      vl_x  = (tmp_x < 0) ? '0 : tmp_x;
    end else if (v_x < 0) begin
      tmp_x = v_x + dec_x;
      vl_x  = (tmp_x > 0) ? '0 : tmp_x;
    end
    vn = sat_w(vl_x + xw_t'(i_cur));

    spk_i = 1'b0;
    v_nxt = '0;
    r_nxt = '0;
    if (r[idx] != '0) begin
      r_nxt = r[idx] - REF_W'(1);
    end else if (vn >= threshold) begin
      spk_i = 1'b1;
      r_nxt = refractory_period;
    end else begin
      v_nxt = vn;
    end

    new_spk_full      = new_spk;
    new_spk_full[idx] = spk_i;
  end

  // The spike vector is published on the last update edge so it lines up with step_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      spike_out <= '0;
      prev_spk  <= '0;
      new_spk   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i] <= '0;
        r[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == UPD) begin
        v[idx]  <= v_nxt;
        r[idx]  <= r_nxt;
        new_spk <= new_spk_full;
        if (idx == LAST) begin
          idx       <= '0;
          spike_out <= new_spk_full;
          prev_spk  <= new_spk_full;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rsnn_neuron_array.sv
// Directed bench for rsnn_neuron_array: charge, refractory, leak/saturation,
// recurrence, step handshake and mid-sweep reset.
module tb_rsnn_neuron_array;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             reset, enable, step;
  logic [N*W-1:0]   ext_current;
  logic [W-1:0]     threshold, decay, refractory_period, self_scale, lateral_scale;
  logic [N-1:0]     spike_out;
  logic             step_done, busy;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];

  rsnn_neuron_array #(.N_NEURONS(N), .W(W), .REF_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .ext_current(ext_current), .threshold(threshold), .decay(decay),
    .refractory_period(refractory_period), .self_scale(self_scale),
    .lateral_scale(lateral_scale), .spike_out(spike_out),
    .step_done(step_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; step = 1'b0; enable = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic config_net(input int e0, input int e1, input int thr, input int dec,
                            input int refr, input int ss, input int ls);
    ext_current = {W'(e1), W'(e1), W'(e1), W'(e0)};
    threshold = W'(thr); decay = W'(dec); refractory_period = W'(refr);
    self_scale = W'(ss); lateral_scale = W'(ls);
  endtask

  // One timestep: pulse step, wait (bounded) for step_done, score the spike vector.
  task automatic run_step(input string tag);
    int lat;
    bit seen;
    logic [N-1:0] e;
    step = 1'b1; tick(); step = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat <= 20) begin
      if (step_done) seen = 1'b1;
      else begin tick(); lat++; end
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    if (seen) check({tag, "_latency"}, lat, N + 1);
    e = exp_q.pop_front();
    check({tag, "_spike"}, int'(spike_out), int'(e));
    tick();
  endtask

  initial begin
    int ev [8];
    ext_current = '0; threshold = 8'd50; decay = '0; refractory_period = '0;
    self_scale = '0; lateral_scale = '0;
    do_reset();
    check("reset_spike", int'(spike_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(step_done), 0);
    check("reset_v0", int'($signed(dut.v[0])), 0);

    // Charge: neuron 0 reaches 60 on every third step.
    config_net(20, 0, 50, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) exp_q.push_back((k % 3 == 0) ? 4'b0001 : 4'b0000);
    for (int k = 1; k <= 9; k++) begin
      run_step($sformatf("charge%0d", k));
      check($sformatf("charge%0d_v0", k), int'($signed(dut.v[0])), (k % 3 == 0) ? 0 : 20 * (k % 3));
    end

    // Refractory of 2 timesteps.
    do_reset();
    config_net(20, 0, 50, 0, 2, 0, 0);
    ev = '{20, 40, 0, 0, 0, 20, 40, 0};
    for (int k = 1; k <= 8; k++) exp_q.push_back((k == 3 || k == 8) ? 4'b0001 : 4'b0000);
    for (int k = 1; k <= 8; k++) begin
      run_step($sformatf("refr%0d", k));
      check($sformatf("refr%0d_v0", k), int'($signed(dut.v[0])), ev[k-1]);
    end

    // Leak and saturation.
    do_reset();
    config_net(-128, 0, 100, 5, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(4'b0000);
      run_step($sformatf("sat%0d", k));
      check($sformatf("sat%0d_v0", k), int'($signed(dut.v[0])), -128);
    end
    config_net(0, 0, 100, 5, 0, 0, 0);
    for (int k = 1; k <= 27; k++) begin
      exp_q.push_back(4'b0000);
      run_step($sformatf("leak%0d", k));
      check($sformatf("leak%0d_v0", k), int'($signed(dut.v[0])),
            (-128 + 5 * k > 0) ? 0 : -128 + 5 * k);
    end

    // Recurrence: self feedback keeps neuron 0 firing, lateral inhibition holds the rest.
    do_reset();
    config_net(60, 40, 50, 0, 0, 60, -128);
    ev = '{40, -48, -128, 0, 0, 0, 0, 0};
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(4'b0001);
      run_step($sformatf("rec%0d", k));
      check($sformatf("rec%0d_v1", k), int'($signed(dut.v[1])), ev[k-1]);
      check($sformatf("rec%0d_v3", k), int'($signed(dut.v[3])), ev[k-1]);
    end

    // Handshake timing, with a second step while busy that must be ignored.
    do_reset();
    config_net(20, 0, 50, 0, 0, 0, 0);
    step = 1'b1; tick(); step = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      check($sformatf("hs%0d_busy", k), int'(busy), (k <= N) ? 1 : 0);
      check($sformatf("hs%0d_done", k), int'(step_done), (k == N + 1) ? 1 : 0);
      check($sformatf("hs%0d_spike", k), int'(spike_out), 0);
      step = (k == 1);
      tick();
    end
    step = 1'b0;
    enable = 1'b0; step = 1'b1; tick(); step = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("noen%0d_busy", k), int'(busy), 0);
      check($sformatf("noen%0d_done", k), int'(step_done), 0);
      tick();
    end
    check("hs_v0", int'($signed(dut.v[0])), 20);

    // Reset mid-sweep after spike_out already holds a spike.
    do_reset();
    config_net(20, 0, 50, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back((k == 3) ? 4'b0001 : 4'b0000);
      run_step($sformatf("pre%0d", k));
    end
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    check("mid_busy_before", int'(busy), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_busy", int'(busy), 0);
    check("mid_spike", int'(spike_out), 0);
    check("mid_done", int'(step_done), 0);
    for (int k = 1; k <= N + 2; k++) begin
      check($sformatf("mid_quiet%0d", k), int'(step_done | busy), 0);
      tick();
    end
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back((k == 3) ? 4'b0001 : 4'b0000);
      run_step($sformatf("post%0d", k));
      check($sformatf("post%0d_v0", k), int'($signed(dut.v[0])), (k == 3) ? 0 : 20 * k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
